// File: rtl/alien_fleet_ctrl_pkg.sv
// Shared fleet definitions: game-state encoding and default fleet geometry,
// imported by the controller and by the colour/render logic.
package alien_fleet_ctrl_pkg;

   typedef enum logic [1:0] {
      GS_PLAY = 2'b00,
      GS_WIN  = 2'b01,
      GS_LOSE = 2'b10
   } gameState_t;

   // CELL_W and CELL_H must stay powers of two: hit decode uses shifts/masks.
   localparam int FLEET_COLS    = 6;
   localparam int FLEET_ROWS    = 6;
   localparam int FLEET_CELL_W  = 32;
   localparam int FLEET_CELL_H  = 32;
   localparam int FLEET_ALIEN_W = 24;
   localparam int FLEET_ALIEN_H = 16;
   localparam int FLEET_STEP_X  = 4;
   localparam int FLEET_STEP_Y  = 16;
   localparam int FLEET_X_INIT  = 64;
   localparam int FLEET_Y_INIT  = 32;
   localparam int FLEET_X_MAX   = 640;
   localparam int FLEET_LOSE_Y  = 400;

endpackage

// File: rtl/alien_fleet_ctrl_hit_decode.sv
// Combinational laser-vs-fleet hit test: locates the grid cell under the laser
// tip and reports a hit only over the sprite area of a live alien.
module fleet_hit_decode #(
   parameter int COLS    = 6,
   parameter int ROWS    = 6,
   parameter int CELL_W  = 32,
   parameter int CELL_H  = 32,
   parameter int ALIEN_W = 24,
   parameter int ALIEN_H = 16
) (
   input  logic                          laserActive,
   input  logic [9:0]                    xLaser,
   input  logic [9:0]                    yLaser,
   input  logic [9:0]                    xAlien,
   input  logic [9:0]                    yAlien,
   input  logic [ROWS*COLS-1:0]          alive,
   output logic                          hit,
   output logic [$clog2(ROWS*COLS)-1:0]  index
);

   localparam int IDX_W = $clog2(ROWS*COLS);
   localparam int CW_SH = $clog2(CELL_W);
   localparam int CH_SH = $clog2(CELL_H);

   logic [10:0] dx, dy;
   logic [9:0]  col, row;
   logic        inX, inY, inSprite;

   // Extra top bit flags a laser left of / above the fleet corner.
   assign dx = {1'b0, xLaser} - {1'b0, xAlien};
   assign dy = {1'b0, yLaser} - {1'b0, yAlien};

   assign inX = !dx[10] && (dx[9:0] < 10'(COLS*CELL_W));
   assign inY = !dy[10] && (dy[9:0] < 10'(ROWS*CELL_H));

   assign inSprite = ((dx[9:0] & 10'(CELL_W-1)) < 10'(ALIEN_W)) &&
                     ((dy[9:0] & 10'(CELL_H-1)) < 10'(ALIEN_H));

   assign col   = dx[9:0] >> CW_SH;
   assign row   = dy[9:0] >> CH_SH;
   assign index = IDX_W'(32'(row) * COLS + 32'(col));

   // index is only in range when inX/inY hold, so they gate the alive lookup.
   assign hit = laserActive && inX && inY && inSprite && alive[index];

endmodule

// File: rtl/alien_fleet_ctrl.sv
// Alien fleet controller: marches the fleet, resolves laser kills, keeps score
// and runs the PLAY/WIN/LOSE game state.
module alien_fleet_ctrl
   import alien_fleet_ctrl_pkg::*;
#(
   parameter int COLS    = FLEET_COLS,
   parameter int ROWS    = FLEET_ROWS,
   parameter int CELL_W  = FLEET_CELL_W,
   parameter int CELL_H  = FLEET_CELL_H,
   parameter int ALIEN_W = FLEET_ALIEN_W,
   parameter int ALIEN_H = FLEET_ALIEN_H,
   parameter int STEP_X  = FLEET_STEP_X,
   parameter int STEP_Y  = FLEET_STEP_Y,
   parameter int X_INIT  = FLEET_X_INIT,
   parameter int Y_INIT  = FLEET_Y_INIT,
   parameter int X_MAX   = FLEET_X_MAX,
   parameter int LOSE_Y  = FLEET_LOSE_Y
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 restart,
   input  logic                 laserActive,
   input  logic [9:0]           xLaser,
   input  logic [9:0]           yLaser,
   output logic [9:0]           xAlien,
   output logic [9:0]           yAlien,
   output logic [ROWS*COLS-1:0] alive,
   output logic                 killingAlien,
   output logic [5:0]           score,
   output logic [1:0]           gameState
);

   localparam int IDX_W = $clog2(ROWS*COLS);

   gameState_t       state, stateNext;
   logic             movingLeft;
   logic             hit;
   logic [IDX_W-1:0] hitIdx;
   logic             atRight, atLeft, loseCond, allDead, playActive, reload;

   fleet_hit_decode #(
      .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .CELL_H(CELL_H),
      .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H)
   ) uHitDecode (
      .laserActive(laserActive),
      .xLaser     (xLaser),
      .yLaser     (yLaser),
      .xAlien     (xAlien),
      .yAlien     (yAlien),
      .alive      (alive),
      .hit        (hit),
      .index      (hitIdx)
   );

   assign atRight  = (12'(xAlien) + 12'(COLS*CELL_W + STEP_X)) > 12'(X_MAX);
   assign atLeft   = xAlien < 10'(STEP_X);
   assign loseCond = (12'(yAlien) + 12'(ROWS*CELL_H)) >= 12'(LOSE_Y);
   assign allDead  = (alive == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= GS_PLAY;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         GS_PLAY: begin
            if (loseCond)     stateNext = GS_LOSE;
            else if (allDead) stateNext = GS_WIN;
         end
         GS_WIN, GS_LOSE: if (restart) stateNext = GS_PLAY;
         default:         stateNext = GS_PLAY;
      endcase
   end

   // Freeze motion and kills on the exit edge too, so WIN/LOSE start clean.
   assign playActive = (state == GS_PLAY) && (stateNext == GS_PLAY);
   assign reload     = (state != GS_PLAY) && restart;
   assign gameState  = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         xAlien       <= 10'(X_INIT);
         yAlien       <= 10'(Y_INIT);
         movingLeft   <= 1'b0;
         alive        <= '1;
         score        <= '0;
         killingAlien <= 1'b0;
      end else if (reload) begin
         xAlien       <= 10'(X_INIT);
         yAlien       <= 10'(Y_INIT);
         movingLeft   <= 1'b0;
         alive        <= '1;
         score        <= '0;
         killingAlien <= 1'b0;
      end else begin
         killingAlien <= 1'b0;
         if (playActive) begin
            if (tick) begin
               // Edge hit: drop a row and reverse, x stays put this tick.
               if (movingLeft) begin
                  if (atLeft) begin
                     yAlien     <= yAlien + 10'(STEP_Y);
                     movingLeft <= 1'b0;
                  end else begin
                     xAlien <= xAlien - 10'(STEP_X);
                  end
               end else begin
                  if (atRight) begin
                     yAlien     <= yAlien + 10'(STEP_Y);
                     movingLeft <= 1'b1;
                  end else begin
                     xAlien <= xAlien + 10'(STEP_X);
                  end
               end
            end
            if (hit) begin
               alive[hitIdx] <= 1'b0;
               score         <= score + 6'd1;
               killingAlien  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Directed bench for alien_fleet_ctrl: march, edge bounce, kills, WIN, LOSE,
// restart and asynchronous reset during a kill pulse.
module tb_alien_fleet_ctrl;
   import alien_fleet_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tick = 1'b0;
   logic        restart = 1'b0;
   logic        laserActive = 1'b0;
   logic [9:0]  xLaser = '0;
   logic [9:0]  yLaser = '0;
   logic [9:0]  xAlien, yAlien;
   logic [35:0] alive;
   logic        killingAlien;
   logic [5:0]  score;
   logic [1:0]  gameState;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [35:0] ALL1 = '1;

   always #5 clk = ~clk;

   alien_fleet_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .restart     (restart),
      .laserActive (laserActive),
      .xLaser      (xLaser),
      .yLaser      (yLaser),
      .xAlien      (xAlien),
      .yAlien      (yAlien),
      .alive       (alive),
      .killingAlien(killingAlien),
      .score       (score),
      .gameState   (gameState)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tickOnce();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b0; tick = 1'b0; restart = 1'b0; laserActive = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      int n;

      // reset values
      step();
      chk("rst_x",     64'(xAlien), 64'(64));
      chk("rst_y",     64'(yAlien), 64'(32));
      chk("rst_alive", 64'(alive), 64'(ALL1));
      chk("rst_kill",  64'(killingAlien), 64'(0));
      chk("rst_score", 64'(score), 64'(0));
      chk("rst_state", 64'(gameState), 64'(GS_PLAY));
      reset = 1'b1;

      // march right: 10 ticks
      repeat (10) tickOnce();
      chk("march_x",     64'(xAlien), 64'(104));
      chk("march_y",     64'(yAlien), 64'(32));
      chk("march_alive", 64'(alive), 64'(ALL1));
      chk("march_score", 64'(score), 64'(0));

      // right edge: 444+196=640 still moves, 448+196=644 bounces
      repeat (85) tickOnce();
      chk("edge_x444", 64'(xAlien), 64'(444));
      tickOnce();
      chk("edge_x448", 64'(xAlien), 64'(448));
      chk("edge_y32",  64'(yAlien), 64'(32));
      tickOnce();
      chk("bounce_x", 64'(xAlien), 64'(448));
      chk("bounce_y", 64'(yAlien), 64'(48));
      tickOnce();
      chk("left_x", 64'(xAlien), 64'(444));
      chk("left_y", 64'(yAlien), 64'(48));

      // single kill at index 13, laser held
      doReset();
      xLaser = 10'd101; yLaser = 10'd99; laserActive = 1'b1;
      step();
      chk("k13_pulse", 64'(killingAlien), 64'(1));
      chk("k13_alive", 64'(alive), 64'(ALL1 & ~(36'd1 << 13)));
      chk("k13_score", 64'(score), 64'(1));
      step();
      chk("k13_pulse_end", 64'(killingAlien), 64'(0));
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold_kill", 64'(killingAlien), 64'(0));
      end
      chk("hold_score", 64'(score), 64'(1));

      // restart while playing is ignored
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("play_restart_score", 64'(score), 64'(1));
      chk("play_restart_state", 64'(gameState), 64'(GS_PLAY));

      // gap between sprites, then inactive laser over a live alien
      xLaser = 10'd90; yLaser = 10'd40;
      step(); step();
      chk("gap_score", 64'(score), 64'(1));
      chk("gap_kill",  64'(killingAlien), 64'(0));
      laserActive = 1'b0; xLaser = 10'd64; yLaser = 10'd32;
      step();
      chk("inactive_score", 64'(score), 64'(1));
      chk("inactive_alive0", 64'(alive[0]), 64'(1));

      // tick and hit on the same edge: hit uses pre-move position
      laserActive = 1'b1; tick = 1'b1;
      step();
      tick = 1'b0; laserActive = 1'b0;
      chk("tickhit_x",     64'(xAlien), 64'(68));
      chk("tickhit_alive", 64'(alive), 64'(ALL1 & ~(36'd1 << 13) & ~36'd1));
      chk("tickhit_score", 64'(score), 64'(2));
      chk("tickhit_kill",  64'(killingAlien), 64'(1));

      // kill all 36 -> WIN one cycle later
      doReset();
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 6; c++) begin
            xLaser = 10'(64 + c*32); yLaser = 10'(32 + r*32); laserActive = 1'b1;
            step();
         end
      end
      laserActive = 1'b0;
      chk("all_alive", 64'(alive), 64'(0));
      chk("all_score", 64'(score), 64'(36));
      chk("all_state_play", 64'(gameState), 64'(GS_PLAY));
      step();
      chk("win_state", 64'(gameState), 64'(GS_WIN));
      chk("win_kill",  64'(killingAlien), 64'(0));
      repeat (3) tickOnce();
      chk("win_hold_x", 64'(xAlien), 64'(64));
      chk("win_hold_y", 64'(yAlien), 64'(32));
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("restart_state", 64'(gameState), 64'(GS_PLAY));
      chk("restart_alive", 64'(alive), 64'(ALL1));
      chk("restart_score", 64'(score), 64'(0));
      chk("restart_x",     64'(xAlien), 64'(64));

      // descend to y=208 (11 bounces, last one at the right edge) -> LOSE
      n = 0;
      while (yAlien < 10'd208 && n < 4000) begin
         tickOnce();
         n++;
      end
      chk("lose_y208", 64'(yAlien), 64'(208));
      chk("lose_x448", 64'(xAlien), 64'(448));
      chk("lose_pre_state", 64'(gameState), 64'(GS_PLAY));
      step();
      chk("lose_state", 64'(gameState), 64'(GS_LOSE));
      tickOnce();
      chk("lose_hold_y", 64'(yAlien), 64'(208));
      chk("lose_hold_x", 64'(xAlien), 64'(448));
      xLaser = 10'd448; yLaser = 10'd208; laserActive = 1'b1;
      step();
      laserActive = 1'b0;
      chk("lose_no_kill",  64'(killingAlien), 64'(0));
      chk("lose_no_score", 64'(score), 64'(0));

      // restart from LOSE, then async reset during a kill pulse
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("lose_restart_state", 64'(gameState), 64'(GS_PLAY));
      xLaser = 10'd101; yLaser = 10'd99; laserActive = 1'b1;
      step();
      chk("midkill_pulse", 64'(killingAlien), 64'(1));
      #1 reset = 1'b0;
      #1;
      chk("midkill_rst_kill",  64'(killingAlien), 64'(0));
      chk("midkill_rst_alive", 64'(alive), 64'(ALL1));
      chk("midkill_rst_score", 64'(score), 64'(0));
      laserActive = 1'b0;
      step();
      reset = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
